// File: rtl/mi_issue_queue.sv
// mi_issue_queue: circular instruction buffer feeding the two decoder slots.
// Accepts one or two fetched instructions per cycle, presents up to two head
// entries, and suppresses slot 1 on intra-pair hazards or control flow in slot 0.
// Optional build macro MI_ISSUE_STATS_EN adds a dual-issue cycle counter (dual_cnt_o).
module mi_issue_queue #(
    parameter int unsigned INST_DW = 32,
    parameter int unsigned INST_AW = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned PTR_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_valid_i,
    output logic               fetch_ready_o,
    input  logic [INST_AW-1:0] fetch_pc_i,
    input  logic [INST_DW-1:0] fetch_inst0_i,
    input  logic [INST_DW-1:0] fetch_inst1_i,
    input  logic               fetch_inst1_valid_i,
    input  logic               flush_i,
    input  logic               issue_ready_i,
    output logic               issue0_valid_o,
    output logic [INST_DW-1:0] issue0_inst_o,
    output logic [INST_AW-1:0] issue0_pc_o,
    output logic               issue1_valid_o,
    output logic [INST_DW-1:0] issue1_inst_o,
    output logic [INST_AW-1:0] issue1_pc_o,
    output logic [PTR_W:0]     count_o
`ifdef MI_ISSUE_STATS_EN
    ,
    output logic [31:0]        dual_cnt_o
`endif
);

    localparam int unsigned CW = PTR_W + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);
    localparam logic [INST_DW-1:0] NOP = INST_DW'(32'h0000_0013);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic [INST_AW-1:0] pc_mem   [DEPTH];
    logic [INST_DW-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nx1, wr_ptr_nx1;
    logic [CW-1:0]    count, count_next;

    logic [INST_DW-1:0] head0, head1;
    logic [6:0]         op0, op1;
    logic [4:0]         rd0, rd1, rs1_1, rs2_1;
    logic               ctrl0, wr0, wr1, use_rs1, use_rs2, raw, waw;
    logic               v0, v1;
    logic               push, pop;
    logic [1:0]         push_n, pop_n;

    function automatic logic writes_rd(input logic [6:0] op);
        return op inside {OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};
    endfunction

    assign rd_ptr_nx1 = rd_ptr + PTR_W'(1);
    assign wr_ptr_nx1 = wr_ptr + PTR_W'(1);

    // Head decode and hazard detection for the presented pair
    always_comb begin
        head0   = inst_mem[rd_ptr];
        head1   = inst_mem[rd_ptr_nx1];
        op0     = head0[6:0];
        op1     = head1[6:0];
        rd0     = head0[11:7];
        rd1     = head1[11:7];
        rs1_1   = head1[19:15];
        rs2_1   = head1[24:20];
        ctrl0   = op0 inside {OPC_BRANCH, OPC_JAL, OPC_JALR};
        wr0     = writes_rd(op0) && (rd0 != 5'd0);
        wr1     = writes_rd(op1);
        use_rs1 = op1 inside {OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR};
        use_rs2 = op1 inside {OPC_OP, OPC_STORE, OPC_BRANCH};
        raw     = wr0 && ((use_rs1 && rs1_1 == rd0) || (use_rs2 && rs2_1 == rd0));
        waw     = wr0 && wr1 && (rd1 == rd0);
        v0      = count >= CW'(1);
        v1      = (count >= CW'(2)) && !ctrl0 && !raw && !waw;
    end

    // Slot outputs; invalid slots show a NOP at pc 0
    always_comb begin
        issue0_valid_o = v0;
        issue1_valid_o = v1;
        issue0_inst_o  = v0 ? head0 : NOP;
        issue0_pc_o    = v0 ? pc_mem[rd_ptr] : '0;
        issue1_inst_o  = v1 ? head1 : NOP;
        issue1_pc_o    = v1 ? pc_mem[rd_ptr_nx1] : '0;
        fetch_ready_o  = count <= READY_MAX;
        count_o        = count;
    end

    // Push/pop amounts; ready uses the pre-pop occupancy
    always_comb begin
        push       = fetch_valid_i && fetch_ready_o && !flush_i;
        pop        = issue_ready_i && !flush_i;
        push_n     = push ? (fetch_inst1_valid_i ? 2'd2 : 2'd1) : 2'd0;
        pop_n      = pop ? ({1'b0, v0} + {1'b0, v1}) : 2'd0;
        count_next = count + CW'(push_n) - CW'(pop_n);
    end

    // Pointer and occupancy state; flush returns to the empty origin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop_n);
            wr_ptr <= wr_ptr + PTR_W'(push_n);
            count  <= count_next;
        end
    end

    // Entry storage; contents are not reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc_i;
            inst_mem[wr_ptr] <= fetch_inst0_i;
            if (fetch_inst1_valid_i) begin
                pc_mem[wr_ptr_nx1]   <= fetch_pc_i + INST_AW'(4);
                inst_mem[wr_ptr_nx1] <= fetch_inst1_i;
            end
        end
    end

`ifdef MI_ISSUE_STATS_EN
    logic [31:0] dual_cnt;

    // Count cycles where both slots issue; survives flush, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dual_cnt <= '0;
        end else if (pop && v1) begin
            dual_cnt <= dual_cnt + 32'd1;
        end
    end

    assign dual_cnt_o = dual_cnt;
`endif

endmodule

// File: doc/mi_issue_queue.md
Name: mi_issue_queue

Overview:
Instruction buffer and dual-issue selector on the supply side of the two-issue decoders (slot 0 and slot 1 ID stages). It accepts fetched instruction pairs into a small circular FIFO. Each cycle it presents up to two head-of-queue instructions to the decoders. Slot 1 is suppressed on intra-pair register hazards or when slot 0 is control flow. A flush discards all buffered instructions on branch/jump redirect.

Parameters:
INST_DW, 32, instruction width
INST_AW, 32, PC width
DEPTH, 8, FIFO entries (power of two, >= 4)
PTR_W, 3, log2(DEPTH)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
fetch_valid_i  input  1  fetch pair valid
fetch_ready_o  output  1  queue can accept a pair this cycle
fetch_pc_i  input  INST_AW  PC of fetch_inst0_i; inst1 PC = fetch_pc_i+4
fetch_inst0_i  input  INST_DW  first fetched instruction
fetch_inst1_i  input  INST_DW  second fetched instruction
fetch_inst1_valid_i  input  1  fetch_inst1_i present (0 = single push)
flush_i  input  1  redirect: discard queue contents
issue_ready_i  input  1  decoders accept presented slots this cycle
issue0_valid_o  output  1  slot 0 valid
issue0_inst_o  output  INST_DW  slot 0 instruction
issue0_pc_o  output  INST_AW  slot 0 PC
issue1_valid_o  output  1  slot 1 valid
issue1_inst_o  output  INST_DW  slot 1 instruction
issue1_pc_o  output  INST_AW  slot 1 PC
count_o  output  PTR_W+1  occupied entries

Behaviour:
- Storage: DEPTH entries of {pc, inst}; rd_ptr, wr_ptr (PTR_W bits, wrap modulo DEPTH), count (PTR_W+1 bits).
- Reset (async): rd_ptr=wr_ptr=0, count=0. Hence issue*_valid_o=0, fetch_ready_o=1, count_o=0. Storage contents are not reset.
- fetch_ready_o = (DEPTH - count >= 2). Computed from the current count, before same-cycle pop; combinational.
- Push when fetch_valid_i && fetch_ready_o && !flush_i:
  - write inst0 at wr_ptr;
  - if fetch_inst1_valid_i, also write inst1 (pc+4) at wr_ptr+1;
  - wr_ptr advances by 1 or 2.
- Slot outputs are combinational from head entries (rd_ptr, rd_ptr+1).
- When a slot is invalid, its inst outputs 32'h00000013 (NOP) and its pc outputs 0.
- issue0_valid_o = count >= 1.
- issue1_valid_o = count >= 2 && !ctrl0 && !raw && !waw, where:
  - ctrl0: inst0 opcode is BRANCH 1100011, JAL 1101111 or JALR 1100111.
  - rd0 writes: opcode in {OP 0110011, OP-IMM 0010011, LOAD 0000011, LUI 0110111, AUIPC 0010111, JAL, JALR} and rd0 != 0.
  - raw: rd0 writes && ((inst1 uses rs1 && rs1_1==rd0) || (inst1 uses rs2 && rs2_1==rd0)).
    - rs1 users: OP, OP-IMM, LOAD, STORE 0100011, BRANCH, JALR.
    - rs2 users: OP, STORE, BRANCH.
  - waw: rd0 writes && inst1 writes && rd1==rd0.
- Pop: when issue_ready_i && !flush_i, pop n = issue0_valid_o + issue1_valid_o. rd_ptr += n.
- count_next = count + pushed - popped. Simultaneous push and pop in the same cycle is legal.
- Flush (sync, highest priority): next cycle rd_ptr=wr_ptr=0, count=0. Same-cycle push and pop are discarded. Flush has no effect on rst behaviour.
- Empty: both slots invalid, no pop. count==1: only slot 0 can be valid.
- Full (count > DEPTH-2): fetch_ready_o=0. A fetch_valid_i with ready low is held by fetch and not written.
- Reset asserted mid-operation clears state immediately, regardless of clock.

Optional Feature:
MI_ISSUE_STATS_EN:
- Defined: adds output dual_cnt_o (32 bits, reset 0). It increments by 1 on each cycle where issue_ready_i && !flush_i && issue1_valid_o (two instructions issued). It wraps at 2^32 and is not cleared by flush_i.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset with rst=1 between clock edges -> immediately count_o=0, issue0_valid_o=0, issue0_inst_o=32'h00000013, fetch_ready_o=1.
- Push pc=0x100, inst0=addi x1,x0,1 (0x00100093), inst1=addi x2,x0,2 (0x00200113), then issue_ready_i=1 -> both valid, issue1_pc_o=0x104; count 2->0 next cycle.
- Push addi x1,x0,1 then add x3,x1,x1 (0x001081B3) -> issue1_valid_o=0 (RAW). After one pop, add appears on slot 0 with pc 0x104.
- Push bne x0,x1,8 (0x00101463) plus addi -> only slot 0 valid. Push 4 pairs without issue_ready_i -> count_o=8 and fetch_ready_o=0 at count 7 and 8.
- Queue holding 5 entries; assert flush_i together with fetch_valid_i -> next cycle count_o=0, wr_ptr=0, pushed pair not stored.
- With MI_ISSUE_STATS_EN, run 3 dual-issue cycles and 2 single-issue cycles -> dual_cnt_o=3.
